spi_slave_if: RTL and testbench
===============================

# spi_slave_if

Serial front end of the SPI-to-RAM path. It deserialises MOSI frames from an external SPI master into 10-bit command words for the downstream single-port RAM, using an `rx_data`/`rx_valid` pulse. It accepts the RAM's 8-bit read data via `tx_data`/`tx_valid` and serialises it back on MISO. SPI bit timing is one bit per `clk` cycle; the master is synchronous to `clk`.

## Interface
- `ADDR_SIZE`, default 8: RAM address/data width. The command word is `ADDR_SIZE+2` bits.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `SS_n` in 1: slave select, active low. Frames one transaction.
- `MOSI` in 1: serial data from the master, MSB first.
- `MISO` out 1: serial read data to the master, MSB first.
- `rx_data` out `ADDR_SIZE+2`: command word to the RAM. Bits [9:8] are the command; bits [7:0] are the address or data.
- `rx_valid` out 1: one-cycle strobe, `rx_data` valid.
- `tx_data` in `ADDR_SIZE`: read data from the RAM.
- `tx_valid` in 1: `tx_data` valid, sampled only while awaiting read data.

## Operation
- Frame format: SS_n low, then 1 select bit, then 10 payload bits (MSB first). Payload bits [9:8] are the command: 00 write address, 01 write data, 10 read address, 11 read data.
- Payload is forwarded unmodified. No check that the select bit equals payload[9].
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Reset state is IDLE.
- IDLE: stay while SS_n=1. If SS_n=0, go to CHK_CMD.
- CHK_CMD: sample MOSI as the select bit.
  - Select 0: go to WRITE.
  - Select 1 and `rd_addr_seen`=0: go to READ_ADD.
  - Select 1 and `rd_addr_seen`=1: go to READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift 10 bits into a shift register with a 4-bit counter (0..9).
  - After the 10th bit: load `rx_data`, pulse `rx_valid`.
  - READ_ADD completion: set `rd_addr_seen`=1.
  - READ_DATA completion: clear `rd_addr_seen`, arm the wait for `tx_valid`.
- READ_DATA wait phase:
  - First cycle `tx_valid`=1: capture `tx_data` into the TX shift register.
  - Drive the 8 bits on MISO, MSB first, one per cycle.
  - Then MISO returns to 0. Extra `tx_valid` pulses during or after the shift are ignored.
- After frame completion with SS_n still low: extra MOSI bits are ignored, no further `rx_valid`. The state is held until SS_n=1.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE; bit counter and TX state are cleared.
  - A partial frame is discarded: no `rx_valid`, `rd_addr_seen` unchanged.
  - An in-progress MISO shift is aborted and MISO goes to 0.
- `rd_addr_seen` persists across frames. WRITE frames do not change it. Only reset and READ_DATA completion clear it.
- `rx_data` holds its last value until the next completed frame.

## Timing
- Reset values: MISO=0, `rx_valid`=0, `rx_data`=0, `rd_addr_seen`=0, state IDLE, counters 0.
- Edge k: SS_n sampled low in IDLE, so the state becomes CHK_CMD.
- Edge k+1: select bit sampled.
- Edges k+2..k+11: payload bits 9..0 sampled.
- After edge k+11: `rx_data` is valid and `rx_valid`=1 for exactly one cycle. It drops after edge k+12.
- Read data: if `tx_valid` is sampled high at edge m, MISO = `tx_data[7]` after edge m+1 and `tx_data[0]` after edge m+8. MISO=0 after edge m+9.
  - With the RAM's 2-cycle latency, m = k+13.
- `tx_valid` may arrive any number of cycles later, as long as SS_n stays low.
- Reset asserted mid-frame: all state returns to reset values at that edge. Reset overrides SS_n.
- Minimum SS_n high time between frames: 1 cycle.

## Test plan
- Reset with SS_n=0 and MOSI toggling -> MISO=0, `rx_valid`=0, `rx_data`=0. After release with SS_n=1 the block stays IDLE.
- Frame select 0 + payload 10'b00_1010_0101 -> `rx_data`=0x0A5 with a single-cycle `rx_valid` after edge k+11. MISO stays 0.
- Write-data frame 10'b01_0011_1100 -> `rx_data`=0x13C with one pulse. `rd_addr_seen` unchanged.
- Read-address frame 10'b10_1010_0101, then a read-data frame with select 1 -> the second frame enters READ_DATA and emits `rx_data`=0x3xx. Model `tx_valid` with `tx_data`=0xC3 two cycles later -> MISO shows 1,1,0,0,0,0,1,1 on consecutive cycles, then 0, and `rd_addr_seen`=0.
- Select 1 with no prior read-address frame -> READ_ADD path is taken and the flag is set. A `tx_valid` pulse during this frame leaves MISO at 0.
- SS_n raised after 5 payload bits -> no `rx_valid`, IDLE on the next cycle. A following full frame decodes correctly.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI slave: deserialises 1 select bit plus a 10-bit command into rx_data/rx_valid, and serialises RAM read data onto MISO.
// rx_valid one cycle after the last payload bit; MISO starts one cycle after tx_valid; no backpressure, the master paces everything.
module spi_slave_if #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int W   = ADDR_SIZE + 2;
    localparam int TCW = $clog2(ADDR_SIZE);
    localparam logic [3:0]     LAST_BIT = 4'(W - 1);
    localparam logic [TCW-1:0] LAST_TX  = TCW'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state, next_state;

    logic [W-2:0]         shift_reg;
    logic [3:0]           bit_cnt;
    logic                 frame_done;
    logic                 rd_addr_seen;
    logic                 tx_wait;
    logic                 tx_active;
    logic [TCW-1:0]       tx_cnt;
    logic [ADDR_SIZE-1:0] tx_shift;
    logic                 shift_en;
    logic                 last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (SS_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        next_state = WRITE;
                    end else if (rd_addr_seen) begin
                        next_state = READ_DATA;
                    end else begin
                        next_state = READ_ADD;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // Once a frame has completed, the state is parked until SS_n rises.
    always_comb begin
        shift_en = 1'b0;
        case (state)
            WRITE, READ_ADD, READ_DATA: shift_en = !SS_n && !frame_done;
            default:                    shift_en = 1'b0;
        endcase
    end

    assign last_bit = shift_en && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            frame_done   <= 1'b0;
            rd_addr_seen <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_wait      <= 1'b0;
            tx_active    <= 1'b0;
            tx_cnt       <= '0;
            tx_shift     <= '0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_wait    <= 1'b0;
                tx_active  <= 1'b0;
                tx_cnt     <= '0;
                MISO       <= 1'b0;
            end else begin
                if (shift_en) begin
                    shift_reg <= {shift_reg[W-3:0], MOSI};
                    if (last_bit) begin
                        rx_data    <= {shift_reg, MOSI};
                        rx_valid   <= 1'b1;
                        frame_done <= 1'b1;
                        bit_cnt    <= '0;
                        if (state == READ_ADD) begin
                            rd_addr_seen <= 1'b1;
                        end
                        if (state == READ_DATA) begin
                            rd_addr_seen <= 1'b0;
                            tx_wait      <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                // Only the first tx_valid after a read-data frame is taken.
                if (tx_wait && tx_valid) begin
                    tx_shift  <= tx_data;
                    tx_wait   <= 1'b0;
                    tx_active <= 1'b1;
                    tx_cnt    <= '0;
                end

                if (tx_active) begin
                    MISO     <= tx_shift[ADDR_SIZE-1];
                    tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                    tx_cnt   <= tx_cnt + TCW'(1);
                    if (tx_cnt == LAST_TX) begin
                        tx_active <= 1'b0;
                    end
                end else begin
                    MISO <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frames are driven one bit per clock, outputs sampled 1 ns after each rising edge.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int vecs = 0;
    int errs = 0;

    spi_slave_if #(.ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives SS_n low, the select bit and the top nbits of the payload; after the
    // final bit the time is just past edge k+11 for a full frame.
    task automatic send_frame(input logic sel, input logic [9:0] p, input int nbits,
                              output int pulses, output logic last_hi, output logic miso_hi);
        pulses  = 0;
        miso_hi = 1'b0;
        SS_n    = 1'b0;
        MOSI    = 1'b0;
        tick();
        MOSI = sel;
        tick();
        if (rx_valid) pulses++;
        miso_hi |= MISO;
        for (int i = 9; i > 9 - nbits; i--) begin
            MOSI = p[i];
            tick();
            if (rx_valid) pulses++;
            miso_hi |= MISO;
        end
        last_hi = rx_valid;
    endtask

    task automatic end_frame;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic any_hi;
        rst      = 1'b1;
        SS_n     = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            MOSI = i[0];
            tick();
        end
        vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        vecs++; if (rx_data !== 10'h000) begin errs++; $display("FAIL reset_rx_data: got %h expected 000", rx_data); end
        rst      = 1'b0;
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        any_hi   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MOSI = ~i[0];
            tick();
            any_hi |= rx_valid | MISO;
        end
        vecs++; if (any_hi !== 1'b0) begin errs++; $display("FAIL idle_quiet: got %b expected 0", any_hi); end
    endtask

    task automatic test_write_addr;
        int   pulses;
        logic last_hi, miso_hi, any_hi;
        send_frame(1'b0, 10'b00_1010_0101, 10, pulses, last_hi, miso_hi);
        vecs++; if (last_hi !== 1'b1) begin errs++; $display("FAIL wa_valid_at_k11: got %b expected 1", last_hi); end
        vecs++; if (pulses != 1) begin errs++; $display("FAIL wa_pulse_count: got %0d expected 1", pulses); end
        vecs++; if (rx_data !== 10'h0A5) begin errs++; $display("FAIL wa_rx_data: got %h expected 0a5", rx_data); end
        tick();
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL wa_valid_drop: got %b expected 0", rx_valid); end
        any_hi = miso_hi;
        for (int i = 0; i < 12; i++) begin
            MOSI = i[0];
            tick();
            any_hi |= rx_valid | MISO;
        end
        vecs++; if (any_hi !== 1'b0) begin errs++; $display("FAIL wa_extra_bits: got %b expected 0", any_hi); end
        vecs++; if (rx_data !== 10'h0A5) begin errs++; $display("FAIL wa_rx_hold: got %h expected 0a5", rx_data); end
        end_frame();
    endtask

    task automatic test_write_data;
        int   pulses;
        logic last_hi, miso_hi;
        send_frame(1'b0, 10'b01_0011_1100, 10, pulses, last_hi, miso_hi);
        vecs++; if (last_hi !== 1'b1 || pulses != 1) begin errs++; $display("FAIL wd_pulse: got last=%b count=%0d expected last=1 count=1", last_hi, pulses); end
        vecs++; if (rx_data !== 10'h13C) begin errs++; $display("FAIL wd_rx_data: got %h expected 13c", rx_data); end
        vecs++; if (miso_hi !== 1'b0) begin errs++; $display("FAIL wd_miso: got %b expected 0", miso_hi); end
        end_frame();
    endtask

    task automatic test_read;
        int         pulses;
        logic       last_hi, miso_hi;
        logic [7:0] exp;
        send_frame(1'b1, 10'b10_1010_0101, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h2A5 || pulses != 1) begin errs++; $display("FAIL ra_frame: got data=%h count=%0d expected data=2a5 count=1", rx_data, pulses); end
        end_frame();
        send_frame(1'b0, 10'b01_0101_0101, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h155) begin errs++; $display("FAIL rd_mid_write: got %h expected 155", rx_data); end
        end_frame();
        send_frame(1'b1, 10'b11_0000_0000, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h300 || last_hi !== 1'b1 || pulses != 1) begin errs++; $display("FAIL rd_frame: got data=%h last=%b count=%0d expected 300/1/1", rx_data, last_hi, pulses); end
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL rd_miso_pre: got %b expected 0", MISO); end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        exp = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                tx_valid = 1'b1;
                tx_data  = 8'h00;
            end
            tick();
            tx_valid = 1'b0;
            vecs++; if (MISO !== exp[7-i]) begin errs++; $display("FAIL rd_miso_bit%0d: got %b expected %b", 7 - i, MISO, exp[7-i]); end
        end
        tick();
        vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL rd_miso_post: got %b expected 0", MISO); end
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        miso_hi  = MISO;
        tick();
        miso_hi |= MISO;
        tick();
        miso_hi |= MISO;
        vecs++; if (miso_hi !== 1'b0) begin errs++; $display("FAIL rd_late_tx_valid: got %b expected 0", miso_hi); end
        end_frame();
    endtask

    task automatic test_read_flag;
        int   pulses;
        logic last_hi, miso_hi;
        send_frame(1'b1, 10'b10_0110_0110, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h266 || pulses != 1) begin errs++; $display("FAIL rf_addr_frame: got data=%h count=%0d expected 266/1", rx_data, pulses); end
        miso_hi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tx_valid = (i < 3);
            tx_data  = 8'hFF;
            tick();
            miso_hi |= MISO;
        end
        tx_valid = 1'b0;
        vecs++; if (miso_hi !== 1'b0) begin errs++; $display("FAIL rf_readadd_miso: got %b expected 0", miso_hi); end
        end_frame();
        send_frame(1'b1, 10'b11_1111_1111, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h3FF) begin errs++; $display("FAIL rf_data_frame: got %h expected 3ff", rx_data); end
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        tick();
        vecs++; if (MISO !== 1'b1) begin errs++; $display("FAIL rf_miso_bit7: got %b expected 1", MISO); end
        tick();
        vecs++; if (MISO !== 1'b1) begin errs++; $display("FAIL rf_miso_bit6: got %b expected 1", MISO); end
        end_frame();
        vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL rf_abort_miso: got %b expected 0", MISO); end
        tick();
        vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL rf_abort_stays: got %b expected 0", MISO); end
    endtask

    task automatic test_abort;
        int   pulses;
        logic last_hi, miso_hi;
        send_frame(1'b0, 10'b11_1010_1010, 5, pulses, last_hi, miso_hi);
        end_frame();
        vecs++; if (pulses != 0 || rx_valid !== 1'b0) begin errs++; $display("FAIL ab_no_valid: got count=%0d valid=%b expected 0/0", pulses, rx_valid); end
        vecs++; if (rx_data !== 10'h3FF) begin errs++; $display("FAIL ab_rx_hold: got %h expected 3ff", rx_data); end
        send_frame(1'b0, 10'b00_1111_0000, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h0F0 || pulses != 1) begin errs++; $display("FAIL ab_next_frame: got data=%h count=%0d expected 0f0/1", rx_data, pulses); end
        end_frame();
        // An aborted read-address frame must not set the flag: the next select-1 frame is still a read address.
        send_frame(1'b1, 10'b10_0000_0001, 5, pulses, last_hi, miso_hi);
        end_frame();
        send_frame(1'b1, 10'b10_0001_0001, 10, pulses, last_hi, miso_hi);
        end_frame();
        send_frame(1'b1, 10'b11_0001_0001, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h311) begin errs++; $display("FAIL ab_rd_frame: got %h expected 311", rx_data); end
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        tick();
        vecs++; if (MISO !== 1'b1) begin errs++; $display("FAIL ab_rd_bit7: got %b expected 1", MISO); end
        tick();
        vecs++; if (MISO !== 1'b0) begin errs++; $display("FAIL ab_rd_bit6: got %b expected 0", MISO); end
        end_frame();
    endtask

    task automatic test_reset_mid;
        int   pulses;
        logic last_hi, miso_hi;
        send_frame(1'b0, 10'b10_0000_0001, 7, pulses, last_hi, miso_hi);
        rst = 1'b1;
        tick();
        vecs++; if (rx_valid !== 1'b0 || MISO !== 1'b0 || rx_data !== 10'h000) begin errs++; $display("FAIL rm_reset: got valid=%b miso=%b data=%h expected 0/0/000", rx_valid, MISO, rx_data); end
        rst  = 1'b0;
        SS_n = 1'b1;
        tick();
        send_frame(1'b0, 10'b10_0000_0001, 10, pulses, last_hi, miso_hi);
        vecs++; if (rx_data !== 10'h201 || pulses != 1) begin errs++; $display("FAIL rm_after: got data=%h count=%0d expected 201/1", rx_data, pulses); end
        end_frame();
    endtask

    initial begin
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_read_flag();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
